// File: rtl/seq_divider.sv
// seq_divider: iterative unsigned restoring divider, one quotient bit per clock, start/done handshake
//   clk, rst (async, active-high) | start, dividend, divisor in | busy, done, quotient, remainder, div_by_zero out
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] pr, sh, diff, npr;
  logic [WIDTH-1:0] dvd, dvs, qs, nq;
  logic accept, last, ge, zero;
  always_comb begin
    accept = start && state != S_RUN;
    zero = divisor == '0;
    last = cnt == CW'(1);
    sh = (pr << 1) | {{WIDTH{1'b0}}, dvd[WIDTH-1]};
    diff = sh - {1'b0, dvs};
    // partial remainder stays below the divisor, so a borrow out of the subtract means sh < divisor
    ge = ~diff[WIDTH];
    npr = ge ? diff : sh;
    nq = (qs << 1) | {{(WIDTH-1){1'b0}}, ge};
    nxt = accept ? (zero ? S_DONE : S_RUN)
        : state == S_RUN ? (last ? S_DONE : S_RUN)
        : S_IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else state <= nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      pr <= '0;
      dvd <= '0;
      dvs <= '0;
      qs <= '0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      cnt <= CW'(WIDTH);
      pr <= '0;
      dvd <= dividend;
      dvs <= divisor;
      qs <= '0;
      div_by_zero <= zero;
      if (zero) begin
        quotient <= '1;
        remainder <= dividend;
      end
    end else if (state == S_RUN) begin
      cnt <= cnt - CW'(1);
      pr <= npr;
      dvd <= dvd << 1;
      qs <= nq;
      if (last) begin
        quotient <= nq;
        remainder <= npr[WIDTH-1:0];
      end
    end
  assign busy = state == S_RUN;
  assign done = state == S_DONE;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random scoreboard checks of seq_divider
module tb_seq_divider;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [W-1:0] dividend = '0, divisor = '0;
  logic busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;
  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic z;
    int cyc;
  } exp_t;
  exp_t sb[$];
  int cyc = 0, n_cmp = 0, n_err = 0;
  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    dividend = a;
    divisor = b;
    start = 1'b1;
    e.q = (b == 0) ? {W{1'b1}} : a / b;
    e.r = (b == 0) ? a : a % b;
    e.z = b == 0;
    e.cyc = cyc + 1 + ((b == 0) ? 0 : W);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(input string tag);
    exp_t e;
    int k = 0;
    while (done !== 1'b1 && k < 40) begin
      chk({tag, "_busy_run"}, 64'(busy), 64'(1));
      @(negedge clk);
      k++;
    end
    e = sb.pop_front();
    chk({tag, "_done_cycle"}, 64'(cyc), 64'(e.cyc));
    chk({tag, "_busy_at_done"}, 64'(busy), 64'(0));
    chk({tag, "_quotient"}, 64'(quotient), 64'(e.q));
    chk({tag, "_remainder"}, 64'(remainder), 64'(e.r));
    chk({tag, "_div_by_zero"}, 64'(div_by_zero), 64'(e.z));
  endtask
  function automatic logic [W-1:0] pick();
    int s = $urandom_range(0, 7);
    return (s == 0) ? W'(0) : (s == 1) ? W'(1) : (s == 2) ? W'(255) : W'($urandom_range(0, 255));
  endfunction
  initial begin
    logic [W-1:0] a, b;
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_quotient", 64'(quotient), 64'(0));
    chk("rst_remainder", 64'(remainder), 64'(0));
    chk("rst_dbz", 64'(div_by_zero), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    launch(200, 7);
    wait_done("t200_7");
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'(0));
    repeat (2) @(negedge clk);
    chk("hold_quotient", 64'(quotient), 64'(28));
    chk("hold_remainder", 64'(remainder), 64'(4));
    launch(5, 9);
    wait_done("t5_9");
    @(negedge clk);
    launch(255, 1);
    wait_done("t255_1");
    @(negedge clk);
    launch(77, 0);
    wait_done("t77_0");
    @(negedge clk);
    launch(100, 10);
    wait_done("t100_10");
    @(negedge clk);
    launch(200, 7);
    repeat (2) @(negedge clk);
    dividend = 9;
    divisor = 3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignored_start");
    launch(9, 3);
    wait_done("back_to_back");
    @(negedge clk);
    launch(255, 16);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_quotient", 64'(quotient), 64'(0));
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_done", 64'(done), 64'(0));
    void'(sb.pop_back());
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("arst_no_done", 64'(done), 64'(0));
      @(negedge clk);
    end
    launch(255, 16);
    wait_done("after_rst");
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      a = pick();
      b = pick();
      launch(a, b);
      wait_done("sweep");
      if (b != 0) begin
        chk("sweep_invariant", 64'(quotient) * 64'(b) + 64'(remainder), 64'(a));
        chk("sweep_rem_lt_div", 64'(remainder < b), 64'(1));
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
